// File: rtl/usb_rx_bit_decoder_if.sv
// Symbol-in / byte-out bundle between the wire reader, the bit decoder and the packet receiver.
// master drives line symbols and the strobe; slave (the decoder) returns ready, bytes and framing status.
interface usb_rx_bit_decoder_if;
  logic       fullSpeedRate;
  logic [1:0] RxBitsIn;
  logic       RxWireActive;
  logic       SIERxWEn;
  logic       SIERxRdyOut;
  logic [7:0] RxDataOut;
  logic       RxDataValid;
  logic       RxPktStart;
  logic       RxPktEnd;
  logic       RxPktActive;
  logic       RxBitStuffError;
  logic       RxByteAlignError;

  modport master (
    output fullSpeedRate, RxBitsIn, RxWireActive, SIERxWEn,
    input  SIERxRdyOut, RxDataOut, RxDataValid, RxPktStart, RxPktEnd,
    input  RxPktActive, RxBitStuffError, RxByteAlignError
  );

  modport slave (
    input  fullSpeedRate, RxBitsIn, RxWireActive, SIERxWEn,
    output SIERxRdyOut, RxDataOut, RxDataValid, RxPktStart, RxPktEnd,
    output RxPktActive, RxBitStuffError, RxByteAlignError
  );
endinterface

// File: rtl/usb_rx_bit_decoder.sv
// USB receive bit decoder: NRZI decode, SYNC hunt, bit unstuffing, EOP detection, LSB-first byte assembly.
// Pulses appear 1 clk after the accepting edge; ready drops for one clk after each accepted symbol.
module usb_rx_bit_decoder #(
  parameter int         STUFF_ONES   = 6,
  parameter logic [7:0] SYNC_PATTERN = 8'h80
) (
  input  logic clk,
  input  logic rst,
  usb_rx_bit_decoder_if.slave rx
);

  typedef enum logic [2:0] {IDLE, HUNT, RX_DATA, EOP_SE0, WAIT_EOP} state_t;

  localparam logic [2:0] STUFF_LIMIT = 3'(STUFF_ONES);

  state_t     state_q, state_d;
  logic       prev_j_q, prev_j_d;
  logic [7:0] sync_q, sync_d;
  logic [7:0] byte_q, byte_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] ones_cnt_q, ones_cnt_d;
  logic       rdy_q, rdy_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_vld_q, data_vld_d;
  logic       pkt_start_q, pkt_start_d;
  logic       pkt_end_q, pkt_end_d;
  logic       pkt_active_q, pkt_active_d;
  logic       stuff_err_q, stuff_err_d;
  logic       align_err_q, align_err_d;

  logic       accept, sym_se0, sym_j, sym_k, dec_bit, stuff_hit;
  logic [7:0] sync_shift, byte_shift;

  // J/K polarity swaps between full and low speed; SE0 is the same for both
  assign accept     = rx.SIERxWEn && rdy_q;
  assign sym_se0    = (rx.RxBitsIn == 2'b00);
  assign sym_j      = rx.fullSpeedRate ? (rx.RxBitsIn == 2'b10) : (rx.RxBitsIn == 2'b01);
  assign sym_k      = rx.fullSpeedRate ? (rx.RxBitsIn == 2'b01) : (rx.RxBitsIn == 2'b10);
  assign dec_bit    = (sym_j && prev_j_q) || (sym_k && !prev_j_q);
  assign stuff_hit  = (ones_cnt_q == STUFF_LIMIT);
  assign sync_shift = {dec_bit, sync_q[7:1]};
  assign byte_shift = {dec_bit, byte_q[7:1]};

  always_comb begin
    state_d      = state_q;
    prev_j_d     = prev_j_q;
    sync_d       = sync_q;
    byte_d       = byte_q;
    bit_cnt_d    = bit_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    rdy_d        = !accept;
    data_out_d   = data_out_q;
    data_vld_d   = 1'b0;
    pkt_start_d  = 1'b0;
    pkt_end_d    = 1'b0;
    pkt_active_d = pkt_active_q;
    stuff_err_d  = stuff_err_q;
    align_err_d  = align_err_q;

    if (accept) begin
      if (sym_j || sym_k) prev_j_d = sym_j;
      else if (sym_se0)   prev_j_d = 1'b1;

      unique case (state_q)
        IDLE: begin
          if (sym_k) begin
            state_d = HUNT;
            sync_d  = {1'b0, sync_q[7:1]};
          end
        end
        HUNT: begin
          if (!rx.RxWireActive || sym_se0) begin
            state_d = IDLE;
          end else if (sym_j || sym_k) begin
            sync_d = sync_shift;
            if (sync_shift == SYNC_PATTERN) begin
              state_d      = RX_DATA;
              pkt_start_d  = 1'b1;
              pkt_active_d = 1'b1;
              stuff_err_d  = 1'b0;
              align_err_d  = 1'b0;
              bit_cnt_d    = 3'd0;
              ones_cnt_d   = {2'b00, dec_bit};
            end
          end
        end
        RX_DATA: begin
          if (!rx.RxWireActive) begin
            state_d      = IDLE;
            pkt_active_d = 1'b0;
          end else if (sym_se0) begin
            state_d = EOP_SE0;
          end else if (sym_j || sym_k) begin
            if (stuff_hit) begin
              if (dec_bit) begin
                stuff_err_d = 1'b1;
                state_d     = WAIT_EOP;
              end else begin
                ones_cnt_d = 3'd0;
              end
            end else begin
              byte_d     = byte_shift;
              bit_cnt_d  = bit_cnt_q + 3'd1;
              ones_cnt_d = dec_bit ? ones_cnt_q + 3'd1 : 3'd0;
              if (bit_cnt_q == 3'd7) begin
                data_out_d = byte_shift;
                data_vld_d = 1'b1;
              end
            end
          end
        end
        EOP_SE0: begin
          // A pending stuff bit at EOP means the last byte boundary is suspect
          if (sym_j) begin
            state_d      = IDLE;
            pkt_end_d    = 1'b1;
            pkt_active_d = 1'b0;
            if (bit_cnt_q != 3'd0 || stuff_hit) align_err_d = 1'b1;
          end else if (sym_k) begin
            state_d      = IDLE;
            pkt_end_d    = 1'b1;
            pkt_active_d = 1'b0;
            align_err_d  = 1'b1;
          end
        end
        WAIT_EOP: begin
          if (sym_se0) state_d = EOP_SE0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      prev_j_q     <= 1'b1;
      sync_q       <= 8'h00;
      byte_q       <= 8'h00;
      bit_cnt_q    <= 3'd0;
      ones_cnt_q   <= 3'd0;
      rdy_q        <= 1'b1;
      data_out_q   <= 8'h00;
      data_vld_q   <= 1'b0;
      pkt_start_q  <= 1'b0;
      pkt_end_q    <= 1'b0;
      pkt_active_q <= 1'b0;
      stuff_err_q  <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_j_q     <= prev_j_d;
      sync_q       <= sync_d;
      byte_q       <= byte_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      rdy_q        <= rdy_d;
      data_out_q   <= data_out_d;
      data_vld_q   <= data_vld_d;
      pkt_start_q  <= pkt_start_d;
      pkt_end_q    <= pkt_end_d;
      pkt_active_q <= pkt_active_d;
      stuff_err_q  <= stuff_err_d;
      align_err_q  <= align_err_d;
    end
  end

  assign rx.SIERxRdyOut      = rdy_q;
  assign rx.RxDataOut        = data_out_q;
  assign rx.RxDataValid      = data_vld_q;
  assign rx.RxPktStart       = pkt_start_q;
  assign rx.RxPktEnd         = pkt_end_q;
  assign rx.RxPktActive      = pkt_active_q;
  assign rx.RxBitStuffError  = stuff_err_q;
  assign rx.RxByteAlignError = align_err_q;

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Directed bench for usb_rx_bit_decoder: NRZI-encodes packets from a line-state model and checks decoded bytes/framing.
module tb_usb_rx_bit_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_rx_bit_decoder_if rx();

  usb_rx_bit_decoder dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx)
  );

  int checks = 0;
  int errors = 0;

  int         start_cnt = 0;
  int         end_cnt   = 0;
  logic [7:0] got_q[$];
  int         start_b, end_b, byte_b;

  logic line_j;
  int   ones;

  always @(negedge clk) begin
    if (rx.RxPktStart)  start_cnt++;
    if (rx.RxPktEnd)    end_cnt++;
    if (rx.RxDataValid) got_q.push_back(rx.RxDataOut);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    start_b = start_cnt;
    end_b   = end_cnt;
    byte_b  = got_q.size();
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] jsym();
    return rx.fullSpeedRate ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [1:0] ksym();
    return rx.fullSpeedRate ? 2'b01 : 2'b10;
  endfunction

  task automatic send(input logic [1:0] b, input logic act);
    int n;
    n = 0;
    while (rx.SIERxRdyOut !== 1'b1 && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rdy_before_strobe", 32'(rx.SIERxRdyOut), 32'd1);
    rx.RxBitsIn     = b;
    rx.RxWireActive = act;
    rx.SIERxWEn     = 1'b1;
    @(posedge clk);
    #1;
    rx.SIERxWEn     = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    if (!b) line_j = ~line_j;
    send(line_j ? jsym() : ksym(), 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit stuff_en);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      if (d[i]) ones++;
      else      ones = 0;
      if (stuff_en && ones == 6) begin
        send_bit(1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic send_sync();
    send(jsym(), 1'b1);
    send(jsym(), 1'b1);
    line_j = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    send_bit(1'b1);
    ones = 1;
  endtask

  task automatic send_eop();
    send(2'b00, 1'b1);
    send(2'b00, 1'b1);
    send(jsym(), 1'b1);
    line_j = 1'b1;
  endtask

  task automatic chk_byte(input string tag, input int idx, input logic [7:0] exp);
    logic [7:0] v;
    v = (byte_b + idx < got_q.size()) ? got_q[byte_b + idx] : 8'hxx;
    chk(tag, 32'(v), 32'(exp));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_seen;
    rst                = 1'b0;
    rx.fullSpeedRate   = 1'b1;
    rx.RxBitsIn        = 2'b10;
    rx.RxWireActive    = 1'b0;
    rx.SIERxWEn        = 1'b0;
    line_j             = 1'b1;
    ones               = 0;

    // 1: reset values, then idle J symbols produce nothing
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy",     32'(rx.SIERxRdyOut),      32'd1);
    chk("rst_data",    32'(rx.RxDataOut),        32'd0);
    chk("rst_valid",   32'(rx.RxDataValid),      32'd0);
    chk("rst_start",   32'(rx.RxPktStart),       32'd0);
    chk("rst_end",     32'(rx.RxPktEnd),         32'd0);
    chk("rst_active",  32'(rx.RxPktActive),      32'd0);
    chk("rst_stuff",   32'(rx.RxBitStuffError),  32'd0);
    chk("rst_align",   32'(rx.RxByteAlignError), 32'd0);
    rst = 1'b1;
    mark();
    repeat (3) send(jsym(), 1'b1);
    settle();
    chk("idle_j_start", 32'(start_cnt - start_b),    32'd0);
    chk("idle_j_bytes", 32'(got_q.size() - byte_b),  32'd0);
    chk("idle_j_end",   32'(end_cnt - end_b),        32'd0);

    // 2: full-speed packet A5, 3C
    mark();
    send_sync();
    settle();
    chk("fs_active_mid", 32'(rx.RxPktActive), 32'd1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_eop();
    settle();
    chk("fs_start",  32'(start_cnt - start_b),   32'd1);
    chk("fs_nbytes", 32'(got_q.size() - byte_b), 32'd2);
    chk_byte("fs_byte0", 0, 8'hA5);
    chk_byte("fs_byte1", 1, 8'h3C);
    chk("fs_end",    32'(end_cnt - end_b),       32'd1);
    chk("fs_active", 32'(rx.RxPktActive),        32'd0);
    chk("fs_stuff",  32'(rx.RxBitStuffError),    32'd0);
    chk("fs_align",  32'(rx.RxByteAlignError),   32'd0);

    // 3: stuffing with and without the inserted bit
    mark();
    send_sync();
    send_byte(8'hFF, 1'b1);
    send_byte(8'h01, 1'b1);
    send_eop();
    settle();
    chk("stuff_nbytes", 32'(got_q.size() - byte_b), 32'd2);
    chk_byte("stuff_byte0", 0, 8'hFF);
    chk_byte("stuff_byte1", 1, 8'h01);
    chk("stuff_err_ok", 32'(rx.RxBitStuffError),    32'd0);
    mark();
    send_sync();
    send_byte(8'hFF, 1'b0);
    send_byte(8'h01, 1'b0);
    send_eop();
    settle();
    chk("nostuff_err",    32'(rx.RxBitStuffError),    32'd1);
    chk("nostuff_nbytes", 32'(got_q.size() - byte_b), 32'd0);
    chk("nostuff_end",    32'(end_cnt - end_b),       32'd1);
    chk("nostuff_align",  32'(rx.RxByteAlignError),   32'd1);

    // 4: byte alignment error; new SYNC clears the stuff error
    mark();
    send_sync();
    send_byte(8'h5A, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_eop();
    settle();
    chk("align_nbytes", 32'(got_q.size() - byte_b), 32'd1);
    chk_byte("align_byte0", 0, 8'h5A);
    chk("align_err",    32'(rx.RxByteAlignError),   32'd1);
    chk("align_stuff",  32'(rx.RxBitStuffError),    32'd0);
    chk("align_end",    32'(end_cnt - end_b),       32'd1);

    // 5: low speed; back-to-back strobes only accepted every other clock
    rx.fullSpeedRate = 1'b0;
    settle();
    rdy_seen        = 0;
    rx.RxBitsIn     = jsym();
    rx.RxWireActive = 1'b1;
    rx.SIERxWEn     = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rx.SIERxRdyOut) rdy_seen++;
    end
    @(posedge clk);
    #1;
    rx.SIERxWEn = 1'b0;
    chk("ls_accepts", 32'(rdy_seen), 32'd4);
    settle();
    mark();
    send_sync();
    send_byte(8'hC3, 1'b1);
    send_eop();
    settle();
    chk("ls_start",  32'(start_cnt - start_b),   32'd1);
    chk("ls_nbytes", 32'(got_q.size() - byte_b), 32'd1);
    chk_byte("ls_byte0", 0, 8'hC3);
    chk("ls_end",    32'(end_cnt - end_b),       32'd1);
    chk("ls_align",  32'(rx.RxByteAlignError),   32'd0);
    rx.fullSpeedRate = 1'b1;
    settle();

    // 6a: reset mid-byte
    mark();
    send_sync();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_active", 32'(rx.RxPktActive), 32'd0);
    chk("mrst_rdy",    32'(rx.SIERxRdyOut), 32'd1);
    rst    = 1'b1;
    line_j = 1'b1;
    settle();
    chk("mrst_end",    32'(end_cnt - end_b),       32'd0);
    chk("mrst_nbytes", 32'(got_q.size() - byte_b), 32'd0);

    // 6b: wire activity lost mid-packet
    mark();
    send_sync();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send(jsym(), 1'b0);
    line_j = 1'b1;
    settle();
    chk("wire_active", 32'(rx.RxPktActive),         32'd0);
    chk("wire_end",    32'(end_cnt - end_b),        32'd0);
    chk("wire_nbytes", 32'(got_q.size() - byte_b),  32'd0);

    // 6c: set the sticky error, then a clean packet clears it
    send_sync();
    send_byte(8'hFF, 1'b0);
    send_eop();
    settle();
    chk("sticky_set", 32'(rx.RxBitStuffError), 32'd1);
    mark();
    send_sync();
    send_byte(8'h81, 1'b1);
    send_eop();
    settle();
    chk("clean_nbytes", 32'(got_q.size() - byte_b), 32'd1);
    chk_byte("clean_byte0", 0, 8'h81);
    chk("clean_stuff",  32'(rx.RxBitStuffError),    32'd0);
    chk("clean_align",  32'(rx.RxByteAlignError),   32'd0);
    chk("clean_end",    32'(end_cnt - end_b),       32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
